// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream fifo and serialises them as 8N1-style frames.
// Optional even-parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifoempty,
  input  logic [WIDTH-1:0] d_out,
  output logic             re,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif
  localparam logic [2:0] STOP   = 3'd6;

  logic [2:0]       state, state_n;
  logic [CW-1:0]    baud_cnt, baud_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shreg, sh_n;
  logic             armed;
  logic             tx_n, re_n, busy_n, fd_n;
  logic             baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // State and registered outputs; armed holds off the first fifo read for one edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      tx         <= 1'b1;
      re         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      shreg      <= sh_n;
      armed      <= 1'b1;
      tx         <= tx_n;
      re         <= re_n;
      busy       <= busy_n;
      frame_done <= fd_n;
`ifdef FIFO_UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
`ifdef FIFO_UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        baud_n = '0;
        if (armed && !fifoempty) state_n = READ;
      end
      READ: state_n = LOAD;
      LOAD: begin
        sh_n    = d_out;
`ifdef FIFO_UART_TX_PARITY_EN
        par_n   = ^d_out;
`endif
        baud_n  = '0;
        state_n = START;
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          sh_n   = shreg >> 1;
          if (bit_cnt == BW'(WIDTH - 1)) begin
            bit_n   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = fifoempty ? IDLE : READ;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      default: begin
        baud_n  = '0;
        bit_n   = '0;
        state_n = IDLE;
      end
    endcase

    tx_n   = 1'b1;
    re_n   = (state_n == READ);
    busy_n = (state_n != IDLE);
    fd_n   = (state_n == STOP) && (baud_n == CW'(CLKS_PER_BIT - 1));
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = sh_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a fifo model feeds words, a cycle-level UART receiver checks frames.
module tb_fifo_uart_tx;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CPB   = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned NB = WIDTH + 3;
`else
  localparam int unsigned NB = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifoempty;
  logic [WIDTH-1:0] d_out = '0;
  logic             re, tx, busy, frame_done;

  fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .fifoempty(fifoempty), .d_out(d_out),
    .re(re), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [0:255];
  int wr_ptr = 0, rd_ptr = 0;
  int cyc = 0, re_cnt = 0;
  int checks = 0, errors = 0;
  int rx_count = 0;
  int done_cyc = 0, last_start = 0;
  bit gap_check = 1'b0, have_prev = 1'b0;
  logic [WIDTH-1:0] exp_q [$];

  assign fifoempty = (wr_ptr == rd_ptr);

  function automatic void check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Registered-read fifo model: word appears on d_out the cycle after re
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re === 1'b1) begin
      check(!fifoempty, "read_nonempty", fifoempty, 0);
      re_cnt <= re_cnt + 1;
      d_out  <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Receiver: samples every cycle of every bit, then scores the frame
  logic [NB-1:0]    bits;
  logic [WIDTH-1:0] rdata, ew;
  bit aborted, hold_bad, fd_bad, busy_bad;
  int bi, ci;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        last_start = cyc;
        if (gap_check && have_prev)
          check(cyc - done_cyc - 1 == 2, "gap", cyc - done_cyc - 1, 2);
        aborted = 0; hold_bad = 0; fd_bad = 0; busy_bad = 0; bits = '0;
        for (int k = 0; k < NB * CPB; k++) begin
          if (k != 0) begin
            @(negedge clk);
            if (rst !== 1'b1) aborted = 1;
          end
          if (aborted) break;
          bi = k / CPB;
          ci = k % CPB;
          if (ci == 0) bits[bi] = tx;
          else if (tx !== bits[bi]) hold_bad = 1;
          if (frame_done !== (k == NB * CPB - 1)) fd_bad = 1;
          if (busy !== 1'b1) busy_bad = 1;
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          have_prev = 0;
        end else begin
          rdata = bits[WIDTH:1];
          check(!hold_bad, "bit_hold", hold_bad, 0);
          check(!fd_bad, "frame_done_timing", fd_bad, 0);
          check(!busy_bad, "busy_in_frame", busy_bad, 0);
          check(bits[0] == 1'b0, "start_bit", bits[0], 0);
          check(bits[NB-1] == 1'b1, "stop_bit", bits[NB-1], 1);
`ifdef FIFO_UART_TX_PARITY_EN
          check(bits[WIDTH+1] == ^rdata, "parity_bit", bits[WIDTH+1], ^rdata);
`endif
          if (exp_q.size() == 0) begin
            check(0, "unexpected_frame", rdata, 0);
          end else begin
            ew = exp_q.pop_front();
            check(rdata == ew, "rx_data", rdata, ew);
          end
          rx_count++;
          done_cyc  = cyc;
          have_prev = 1;
        end
      end
    end
  end

  task automatic wait_rx(input int target, input int budget);
    for (int i = 0; i < budget && rx_count < target; i++) @(negedge clk);
    check(rx_count >= target, "rx_timeout", rx_count, target);
  endtask

  task automatic single_word(input logic [WIDTH-1:0] w);
    int r0, c0, n0;
    @(negedge clk);
    r0 = re_cnt; n0 = rx_count; c0 = cyc; have_prev = 0;
    push_word(w);
    wait_rx(n0 + 1, 200);
    check(re_cnt - r0 == 1, "re_pulses_single", re_cnt - r0, 1);
    check(last_start - c0 == 3, "start_latency", last_start - c0, 3);
    @(negedge clk);
    check(busy == 1'b0, "busy_after_single", busy, 0);
  endtask

  initial begin
    int r0, n0;
    logic [WIDTH-1:0] w;
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check(tx == 1'b1 && re == 1'b0 && busy == 1'b0 && frame_done == 1'b0,
            "reset_outputs", {tx, re, busy, frame_done}, 4'b1000);
    end
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check(tx == 1'b1 && re == 1'b0 && busy == 1'b0, "idle_outputs", {tx, re, busy}, 3'b100);
    end

    single_word(8'hA5);
`ifdef FIFO_UART_TX_PARITY_EN
    single_word(8'h01);
`endif

    // Burst of random words written up front so frames run back to back
    @(negedge clk);
    r0 = re_cnt; n0 = rx_count; have_prev = 0; gap_check = 1;
    for (int i = 0; i < 16; i++) push_word(WIDTH'($urandom));
    wait_rx(n0 + 16, 16 * (NB * CPB + 4) + 50);
    gap_check = 0;
    check(re_cnt - r0 == 16, "re_pulses_burst", re_cnt - r0, 16);
    @(negedge clk);
    check(busy == 1'b0 && fifoempty == 1'b1, "busy_after_burst", {busy, fifoempty}, 2'b01);

    // Abort the first of two words during data bit 3
    @(negedge clk);
    r0 = re_cnt; n0 = rx_count;
    w = WIDTH'($urandom);
    push_word(w);
    push_word(~w);
    for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
    check(tx == 1'b0, "abort_start_seen", tx, 0);
    repeat (CPB * 4 + 1) @(posedge clk);
    #2 rst = 1'b0;
    #1 check(tx == 1'b1 && busy == 1'b0 && re == 1'b0 && frame_done == 1'b0,
             "async_abort", {tx, busy, re, frame_done}, 4'b1000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(re == 1'b0, "no_early_read", re, 0);
    wait_rx(n0 + 1, 200);
    check(re_cnt - r0 == 2, "re_pulses_abort", re_cnt - r0, 2);
    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check(busy == 1'b0 && tx == 1'b1, "final_idle", {busy, tx}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data word width in bits, which is also the frame data-bit count.
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 4, meaning the clk cycles per serial bit; legal values are 2 or more.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-low reset.
REQ-005 Port fifoempty SHALL be an input, 1 bit wide, and is the empty flag from the upstream fifo.
REQ-006 Port d_out SHALL be an input, WIDTH bits wide, and is the read data from the upstream fifo.
REQ-007 Port re SHALL be an output, 1 bit wide, and is the read enable driven to the upstream fifo.
REQ-008 Port tx SHALL be an output, 1 bit wide, and is the serial line output, idle high.
REQ-009 Port busy SHALL be an output, 1 bit wide, and is high whenever the state is not IDLE.
REQ-010 Port frame_done SHALL be an output, 1 bit wide, and is a 1-cycle pulse on the last cycle of STOP.

Function
REQ-011 The FSM SHALL have states IDLE, READ, LOAD, START, DATA, PARITY and STOP; PARITY exists only under REQ-026.
REQ-012 IDLE: fifoempty=0 sampled at an edge -> READ; otherwise remain in IDLE.
REQ-013 READ SHALL last exactly 1 cycle with re=1; re is 0 in every other state; the fifo presents the word on d_out in the following cycle.
REQ-014 LOAD SHALL last 1 cycle; the shift register captures d_out at its closing edge -> START.
REQ-015 First start-bit cycle = 3 cycles after the IDLE edge that saw fifoempty=0.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-017 DATA SHALL send WIDTH bits LSB first, each held CLKS_PER_BIT cycles.
- Bit counter runs 0..WIDTH-1; the shift register shifts right at each bit boundary.
- After bit WIDTH-1 -> PARITY if enabled, else STOP.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; on its last cycle frame_done=1.
- fifoempty=0 at that edge -> READ (back-to-back, 2-cycle high gap).
- Otherwise -> IDLE.
REQ-019 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and clear to 0 on every state change and every bit boundary; it never free-runs in IDLE.
REQ-020 tx SHALL be driven from a register, with no combinational glitch; re MAY be decoded from state.
REQ-021 fifoempty SHALL be ignored in all states except IDLE and the last STOP cycle.
- A fifoempty change mid-frame has no effect on the frame in progress.
REQ-022 The fifo SHALL never be read when empty.
- re=1 only follows a sampled fifoempty=0.
- At most one re pulse per frame.

Reset
REQ-023 While rst=0, outputs SHALL asynchronously take: tx=1, re=0, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 at once); no word is re-read after release.
REQ-025 After rst deassertion, the first READ SHALL occur no earlier than the second rising edge.

Configuration
REQ-026 Macro FIFO_UART_TX_PARITY_EN defined -> the PARITY state SHALL be inserted between DATA and STOP.
- PARITY holds tx = XOR of the WIDTH data bits (even parity) for CLKS_PER_BIT cycles.
- Frame = (WIDTH+3)*CLKS_PER_BIT cycles.
REQ-027 Macro undefined -> no PARITY state or logic SHALL exist; frame = (WIDTH+2)*CLKS_PER_BIT cycles.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-028 Bench SHALL cover: rst=0 for 2 cycles, then release with fifoempty=1 held for 50 cycles -> tx=1, re=0, busy=0 throughout.
REQ-029 Bench SHALL cover: single word 8'hA5, no parity.
- re high exactly 1 cycle.
- tx over 40 cycles = 0,1,0,1,0,0,1,0,1,1 per bit (start, LSB-first data, stop).
- frame_done at cycle 40 of the frame.
REQ-030 Bench SHALL cover: FIFO_UART_TX_PARITY_EN with 8'hA5 -> parity bit 0, frame 44 cycles; with 8'h01 -> parity bit 1.
REQ-031 Bench SHALL cover: 16 random words written, fifo then drained.
- Exactly 16 re pulses.
- Received bytes match write order.
- 2-cycle tx-high gap between frames.
- busy falls after the last frame_done once fifoempty=1.
REQ-032 Bench SHALL cover: rst=0 asserted during DATA bit 3 -> tx=1 and busy=0 asynchronously; after release the next queued word is sent intact, and the aborted word is not resent.
